// File: rtl/ssd1306_pkg.sv
// ----------------------------------------------------------------------------
// ssd1306_pkg
// Shared definitions for the SSD1306 OLED physical-layer engine:
//   - power-sequencer state encoding
//   - default (100 MHz) delay constants and a scaled set for short simulations
//   - helpers that size the shared wait counter from the delay parameters
// ----------------------------------------------------------------------------
package ssd1306_pkg;

    typedef enum logic [2:0] {
        PWR_OFF           = 3'd0,
        PWR_VDD_WAIT      = 3'd1,
        PWR_RES_LOW       = 3'd2,
        PWR_RES_HIGH      = 3'd3,
        PWR_VBAT_WAIT     = 3'd4,
        PWR_READY         = 3'd5,
        PWR_DRAIN         = 3'd6,
        PWR_VBAT_OFF_WAIT = 3'd7
    } pwr_state_e;

    // Defaults for a 100 MHz clock.
    localparam int DEF_CLK_DIV      = 5;
    localparam int DEF_DLY_VDD_CYC  = 100000;
    localparam int DEF_RES_LOW_CYC  = 300;
    localparam int DEF_DLY_VBAT_CYC = 10000000;

    // Scaled set so a full power cycle fits in a few dozen clocks.
    localparam int SIM_CLK_DIV      = 2;
    localparam int SIM_DLY_VDD_CYC  = 10;
    localparam int SIM_RES_LOW_CYC  = 4;
    localparam int SIM_DLY_VBAT_CYC = 20;

    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold (max_val - 1), never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/ssd1306_spi_shifter.sv
// ----------------------------------------------------------------------------
// ssd1306_spi_shifter
// Serialises one byte MSB-first. SCLK idles high; each bit is CLK_DIV cycles
// low followed by CLK_DIV cycles high, SDIN only changes as SCLK falls.
// DC and SDIN keep their last values after the byte.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         start a byte (only asserted while idle)
//   data, dc_in  byte and data/command flag captured on load
//   idle         no byte in flight
//   sclk, sdin   serial clock / data
//   dc           data/command select
// ----------------------------------------------------------------------------
module ssd1306_spi_shifter #(
    parameter int CLK_DIV = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       dc_in,
    output logic       idle,
    output logic       sclk,
    output logic       sdin,
    output logic       dc
);

    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

    logic             active_q, active_d;
    logic             sclk_q, sclk_d;
    logic             sdin_q, sdin_d;
    logic             dc_q, dc_d;
    logic [6:0]       shreg_q, shreg_d;   // bits still to be sent, next at [6]
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;

    // Next-state: load, half-period prescaler, bit stepping on the falling edge.
    always_comb begin
        active_d = active_q;
        sclk_d   = sclk_q;
        sdin_d   = sdin_q;
        dc_d     = dc_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        bit_d    = bit_q;
        if (load) begin
            active_d = 1'b1;
            sclk_d   = 1'b0;
            sdin_d   = data[7];
            dc_d     = dc_in;
            shreg_d  = data[6:0];
            div_d    = DIV_RELOAD;
            bit_d    = 3'd0;
        end else if (active_q) begin
            if (div_q != DIV_ZERO) begin
                div_d = div_q - DIV_ONE;
            end else begin
                div_d = DIV_RELOAD;
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else if (bit_q == 3'd7) begin
                    // End of the last high half-period: SCLK rests high.
                    active_d = 1'b0;
                end else begin
                    sclk_d  = 1'b0;
                    sdin_d  = shreg_q[6];
                    shreg_d = {shreg_q[5:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                end
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            sclk_q   <= 1'b1;
            sdin_q   <= 1'b0;
            dc_q     <= 1'b0;
            shreg_q  <= 7'd0;
            div_q    <= DIV_ZERO;
            bit_q    <= 3'd0;
        end else begin
            active_q <= active_d;
            sclk_q   <= sclk_d;
            sdin_q   <= sdin_d;
            dc_q     <= dc_d;
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
        end
    end

    assign idle = !active_q;
    assign sclk = sclk_q;
    assign sdin = sdin_q;
    assign dc   = dc_q;

endmodule

// File: rtl/ssd1306_spi_ctrl.sv
// ----------------------------------------------------------------------------
// ssd1306_spi_ctrl
// OLED power sequencer plus byte handshake in front of the SPI shifter.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  clock, asynchronous active-low reset
//   pwr_on_req                 level request for panel power
//   pwr_ready                  panel powered, bytes may be sent
//   tx_valid/tx_ready          byte handshake; tx_data, tx_dc captured on accept
//   busy                       shifter active or power sequence in progress
//   SDIN, SCLK, DC             serial interface to the panel
//   RES, VBAT, VDD             active-low reset / supply enables
// ----------------------------------------------------------------------------
module ssd1306_spi_ctrl
    import ssd1306_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int DLY_VDD_CYC  = DEF_DLY_VDD_CYC,
    parameter int RES_LOW_CYC  = DEF_RES_LOW_CYC,
    parameter int DLY_VBAT_CYC = DEF_DLY_VBAT_CYC
) (
    input  logic       S_AXI_ACLK,
    input  logic       S_AXI_ARESETN,
    input  logic       pwr_on_req,
    output logic       pwr_ready,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    output logic       busy,
    output logic       SDIN,
    output logic       SCLK,
    output logic       DC,
    output logic       RES,
    output logic       VBAT,
    output logic       VDD
);

    localparam int CNT_W = cnt_width(max_of3(DLY_VDD_CYC, RES_LOW_CYC, DLY_VBAT_CYC));
    // Waits load N-1 and expire on zero, so each wait lasts exactly N cycles.
    localparam logic [CNT_W-1:0] LD_VDD  = CNT_W'(DLY_VDD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RES  = CNT_W'(RES_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_VBAT = CNT_W'(DLY_VBAT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    pwr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vdd_q, vdd_d;
    logic             vbat_q, vbat_d;
    logic             res_q, res_d;
    logic             pwr_ready_q, pwr_ready_d;
    logic             shift_idle;
    logic             tx_load;

    assign tx_ready = (state_q == PWR_READY) && shift_idle && pwr_on_req;
    assign tx_load  = tx_valid && tx_ready;
    assign busy     = (state_q != PWR_OFF) && !((state_q == PWR_READY) && shift_idle);

    // Power sequencer next-state and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vdd_d       = vdd_q;
        vbat_d      = vbat_q;
        res_d       = res_q;
        pwr_ready_d = pwr_ready_q;
        case (state_q)
            PWR_OFF: begin
                if (pwr_on_req) begin
                    vdd_d   = 1'b0;
                    cnt_d   = LD_VDD;
                    state_d = PWR_VDD_WAIT;
                end else begin
                    state_d = PWR_OFF;
                end
            end
            PWR_VDD_WAIT, PWR_RES_LOW, PWR_RES_HIGH, PWR_VBAT_WAIT: begin
                if (!pwr_on_req) begin
                    // Abort the power-up: drop everything straight back to off.
                    vdd_d   = 1'b1;
                    vbat_d  = 1'b1;
                    res_d   = 1'b1;
                    cnt_d   = CNT_ZERO;
                    state_d = PWR_OFF;
                end else if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    case (state_q)
                        PWR_VDD_WAIT: begin
                            res_d   = 1'b0;
                            cnt_d   = LD_RES;
                            state_d = PWR_RES_LOW;
                        end
                        PWR_RES_LOW: begin
                            res_d   = 1'b1;
                            cnt_d   = LD_RES;
                            state_d = PWR_RES_HIGH;
                        end
                        PWR_RES_HIGH: begin
                            vbat_d  = 1'b0;
                            cnt_d   = LD_VBAT;
                            state_d = PWR_VBAT_WAIT;
                        end
                        default: begin
                            pwr_ready_d = 1'b1;
                            state_d     = PWR_READY;
                        end
                    endcase
                end
            end
            PWR_READY: begin
                if (!pwr_on_req) begin
                    pwr_ready_d = 1'b0;
                    state_d     = PWR_DRAIN;
                end else begin
                    state_d = PWR_READY;
                end
            end
            PWR_DRAIN: begin
                // A byte already in flight is allowed to finish first.
                if (shift_idle) begin
                    vbat_d  = 1'b1;
                    cnt_d   = LD_VBAT;
                    state_d = PWR_VBAT_OFF_WAIT;
                end else begin
                    state_d = PWR_DRAIN;
                end
            end
            PWR_VBAT_OFF_WAIT: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    vdd_d   = 1'b1;
                    state_d = PWR_OFF;
                end
            end
            default: begin
                vdd_d       = 1'b1;
                vbat_d      = 1'b1;
                res_d       = 1'b1;
                pwr_ready_d = 1'b0;
                cnt_d       = CNT_ZERO;
                state_d     = PWR_OFF;
            end
        endcase
    end

    // Power sequencer registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= PWR_OFF;
            cnt_q       <= CNT_ZERO;
            vdd_q       <= 1'b1;
            vbat_q      <= 1'b1;
            res_q       <= 1'b1;
            pwr_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vdd_q       <= vdd_d;
            vbat_q      <= vbat_d;
            res_q       <= res_d;
            pwr_ready_q <= pwr_ready_d;
        end
    end

    assign pwr_ready = pwr_ready_q;
    assign VDD       = vdd_q;
    assign VBAT      = vbat_q;
    assign RES       = res_q;

    ssd1306_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .load  (tx_load),
        .data  (tx_data),
        .dc_in (tx_dc),
        .idle  (shift_idle),
        .sclk  (SCLK),
        .sdin  (SDIN),
        .dc    (DC)
    );

endmodule
